cache_ctrl_lb: RTL and testbench

Parametrised data-cache controller FSM between the RISC-V pipeline (load/store requests, stall) and the cache array / data memory. Successor of the single-word read-allocate controller.
- Adds multi-beat line refill with a beat counter.
- Adds a write policy selectable at elaboration: write-through/no-allocate or write-back/write-allocate.
- In write-back mode, dirty victims are written back before refill.

---
 rtl/cache_ctrl_pkg.sv | 16 +
 rtl/cache_ctrl_lb_if.sv | 36 +++
 rtl/cache_beat_cnt.sv | 23 ++
 rtl/cache_ctrl_lb.sv | 150 +++++++++++++++
 tb/tb_cache_ctrl_lb.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types for the line-buffered data-cache controller: FSM state encoding
// and write-policy selectors.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REFILL    = 3'd1,
    RESPOND   = 3'd2,
    WRITEBACK = 3'd3,
    WT_WAIT   = 3'd4
  } state_t;

  localparam int unsigned WP_THROUGH = 0;
  localparam int unsigned WP_BACK    = 1;

endpackage

// File: rtl/cache_ctrl_lb_if.sv
// Pipeline / cache-array / data-memory control bundle of the cache controller.
interface cache_ctrl_lb_if #(
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned BEAT_W         = $clog2(WORDS_PER_LINE)
);
  logic              mem_read;
  logic              mem_write;
  logic              hit_miss;
  logic              dirty;
  logic              done;
  logic              stall;
  logic              rd_en_cm;
  logic              wr_en_cm;
  logic              mem_to_cache_en;
  logic              rd_en_dm;
  logic              wr_en_dm;
  logic              wb_sel;
  logic [BEAT_W-1:0] beat_idx;
  logic              dirty_set;
  logic              dirty_clr;
  logic              valid_set;

  // Controller side
  modport slave (
    input  mem_read, mem_write, hit_miss, dirty, done,
    output stall, rd_en_cm, wr_en_cm, mem_to_cache_en, rd_en_dm, wr_en_dm,
           wb_sel, beat_idx, dirty_set, dirty_clr, valid_set
  );

  // Pipeline / memory side
  modport master (
    output mem_read, mem_write, hit_miss, dirty, done,
    input  stall, rd_en_cm, wr_en_cm, mem_to_cache_en, rd_en_dm, wr_en_dm,
           wb_sel, beat_idx, dirty_set, dirty_clr, valid_set
  );
endinterface

// File: rtl/cache_beat_cnt.sv
// Line beat counter shared by writeback and refill bursts; last_c flags the
// final beat of a line.
module cache_beat_cnt #(
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned BEAT_W         = $clog2(WORDS_PER_LINE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clr,
  output logic [BEAT_W-1:0] cnt,
  output logic              last_c
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (inc)  cnt <= cnt + BEAT_W'(1);
  end

  assign last_c = (cnt == BEAT_W'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/cache_ctrl_lb.sv
// Data-cache controller with multi-beat line refill and elaboration-time
// write policy. Optional perf counters under CACHE_CTRL_PERF_EN.
module cache_ctrl_lb
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned BEAT_W         = $clog2(WORDS_PER_LINE),
  parameter int unsigned WRITE_BACK     = WP_THROUGH
) (
  input  logic           clk,
  input  logic           rst,
  cache_ctrl_lb_if.slave bus
`ifdef CACHE_CTRL_PERF_EN
  ,
  output logic [31:0]    hit_cnt,
  output logic [31:0]    miss_cnt,
  output logic [31:0]    wb_cnt
`endif
);

  state_t            state_q, state_d;
  logic              op_wr_q, op_wr_d;
  logic              inc, clr, last_c;
  logic [BEAT_W-1:0] cnt;
  logic              rd_req, wr_req;

  // A simultaneous read and write is serviced as a read only
  assign rd_req = bus.mem_read;
  assign wr_req = bus.mem_write & ~bus.mem_read;

  cache_beat_cnt #(
    .WORDS_PER_LINE(WORDS_PER_LINE),
    .BEAT_W        (BEAT_W)
  ) u_beat_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .clr   (clr),
    .cnt   (cnt),
    .last_c(last_c)
  );

  assign bus.beat_idx = cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
    end
  end

  // Next state and output decode; everything stays low while in reset
  always_comb begin
    state_d             = state_q;
    op_wr_d             = op_wr_q;
    inc                 = 1'b0;
    clr                 = 1'b0;
    bus.stall           = 1'b0;
    bus.rd_en_cm        = 1'b0;
    bus.wr_en_cm        = 1'b0;
    bus.mem_to_cache_en = 1'b0;
    bus.rd_en_dm        = 1'b0;
    bus.wr_en_dm        = 1'b0;
    bus.wb_sel          = 1'b0;
    bus.dirty_set       = 1'b0;
    bus.dirty_clr       = 1'b0;
    bus.valid_set       = 1'b0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          if (rd_req || wr_req) begin
            if (bus.hit_miss && (rd_req || WRITE_BACK == WP_BACK)) begin
              bus.rd_en_cm  = rd_req;
              bus.wr_en_cm  = wr_req;
              bus.dirty_set = wr_req;
            end else if (wr_req && WRITE_BACK == WP_THROUGH) begin
              bus.wr_en_cm = bus.hit_miss;
              bus.wr_en_dm = 1'b1;
              bus.stall    = 1'b1;
              state_d      = WT_WAIT;
            end else begin
              bus.stall = 1'b1;
              op_wr_d   = wr_req;
              state_d   = (WRITE_BACK == WP_BACK && bus.dirty) ? WRITEBACK : REFILL;
            end
          end
        end
        WRITEBACK: begin
          bus.stall    = 1'b1;
          bus.wr_en_dm = 1'b1;
          bus.wb_sel   = 1'b1;
          inc          = bus.done;
          if (bus.done && last_c) begin
            clr           = 1'b1;
            bus.dirty_clr = 1'b1;
            state_d       = REFILL;
          end
        end
        REFILL: begin
          bus.stall           = 1'b1;
          bus.rd_en_dm        = 1'b1;
          bus.mem_to_cache_en = bus.done;
          inc                 = bus.done;
          if (bus.done && last_c) begin
            clr           = 1'b1;
            bus.valid_set = 1'b1;
            state_d       = RESPOND;
          end
        end
        RESPOND: begin
          bus.rd_en_cm  = ~op_wr_q;
          bus.wr_en_cm  = op_wr_q;
          bus.dirty_set = op_wr_q;
          state_d       = IDLE;
        end
        WT_WAIT: begin
          bus.wr_en_dm = 1'b1;
          bus.stall    = ~bus.done;
          if (bus.done) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef CACHE_CTRL_PERF_EN
  logic hit_ev, miss_ev, wb_ev;

  assign hit_ev  = (state_q == IDLE) && (rd_req || wr_req) &&  bus.hit_miss;
  assign miss_ev = (state_q == IDLE) && (rd_req || wr_req) && !bus.hit_miss;
  assign wb_ev   = (state_q != WRITEBACK) && (state_d == WRITEBACK);

  // Saturating event counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (hit_ev  && hit_cnt  != '1) hit_cnt  <= hit_cnt  + 32'd1;
      if (miss_ev && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
      if (wb_ev   && wb_cnt   != '1) wb_cnt   <= wb_cnt   + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl_lb.sv
// Bench for cache_ctrl_lb: one write-through and one write-back instance
// checked cycle by cycle against a transaction-level expectation queue.
module tb_cache_ctrl_lb;

  localparam int unsigned WPL = 4;

  typedef struct packed {
    logic rd, wr, hit, dirty, done;
  } in_t;

  typedef struct packed {
    logic       stall, rd_en_cm, wr_en_cm, m2c, rd_en_dm, wr_en_dm, wb_sel;
    logic [1:0] beat_idx;
    logic       dirty_set, dirty_clr, valid_set;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  in_t  in_wt = '0, in_wb = '0;
  out_t o_wt, o_wb;
  vec_t q[$];
  int   n_chk = 0, n_fail = 0;
  int   nhit[2], nmiss[2], nwb[2];
  int   t_stall, t_m2c, t_vset, t_wbsel, t_dclr, t_dset, t_wrdm, t_rdcm, t_wrcm;

  cache_ctrl_lb_if #(.WORDS_PER_LINE(WPL)) if_wt ();
  cache_ctrl_lb_if #(.WORDS_PER_LINE(WPL)) if_wb ();

  assign {if_wt.mem_read, if_wt.mem_write, if_wt.hit_miss, if_wt.dirty, if_wt.done} = in_wt;
  assign {if_wb.mem_read, if_wb.mem_write, if_wb.hit_miss, if_wb.dirty, if_wb.done} = in_wb;
  assign o_wt = {if_wt.stall, if_wt.rd_en_cm, if_wt.wr_en_cm, if_wt.mem_to_cache_en,
                 if_wt.rd_en_dm, if_wt.wr_en_dm, if_wt.wb_sel, if_wt.beat_idx,
                 if_wt.dirty_set, if_wt.dirty_clr, if_wt.valid_set};
  assign o_wb = {if_wb.stall, if_wb.rd_en_cm, if_wb.wr_en_cm, if_wb.mem_to_cache_en,
                 if_wb.rd_en_dm, if_wb.wr_en_dm, if_wb.wb_sel, if_wb.beat_idx,
                 if_wb.dirty_set, if_wb.dirty_clr, if_wb.valid_set};

`ifdef CACHE_CTRL_PERF_EN
  logic [31:0] hc_wt, mc_wt, wc_wt, hc_wb, mc_wb, wc_wb;
`endif

  cache_ctrl_lb #(.WORDS_PER_LINE(WPL), .WRITE_BACK(0)) dut_wt (
    .clk(clk), .rst(rst), .bus(if_wt)
`ifdef CACHE_CTRL_PERF_EN
    , .hit_cnt(hc_wt), .miss_cnt(mc_wt), .wb_cnt(wc_wt)
`endif
  );

  cache_ctrl_lb #(.WORDS_PER_LINE(WPL), .WRITE_BACK(1)) dut_wb (
    .clk(clk), .rst(rst), .bus(if_wb)
`ifdef CACHE_CTRL_PERF_EN
    , .hit_cnt(hc_wb), .miss_cnt(mc_wb), .wb_cnt(wc_wb)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    q.push_back(v);
  endtask

  // Expected cycle stream of one access; lat = cycles per memory beat/word,
  // dn_ign = value of done driven where it must be ignored (IDLE, RESPOND)
  task automatic gen_access(input bit wbm, input bit rd, input bit wr, input bit hit,
                            input bit dty, input int lat, input bit dn_ign);
    in_t  i;
    out_t o;
    bit   ew;
    ew = wr && !rd;
    i = '0; i.rd = rd; i.wr = wr; i.hit = hit; i.dirty = dty; i.done = dn_ign;
    o = '0;
    if (hit && (rd || wbm)) begin
      o.rd_en_cm = rd; o.wr_en_cm = ew; o.dirty_set = ew;
      add(i, o);
      nhit[wbm]++;
    end else if (ew && !wbm) begin
      o.stall = 1'b1; o.wr_en_dm = 1'b1; o.wr_en_cm = hit;
      add(i, o);
      if (hit) nhit[0]++; else nmiss[0]++;
      for (int k = 1; k <= lat; k++) begin
        i.done = (k == lat);
        o = '0; o.wr_en_dm = 1'b1; o.stall = !i.done;
        add(i, o);
      end
    end else begin
      nmiss[wbm]++;
      o.stall = 1'b1;
      add(i, o);
      i.hit = 1'b0;
      if (wbm && dty) begin
        nwb[1]++;
        for (int b = 0; b < WPL; b++)
          for (int k = 1; k <= lat; k++) begin
            i.done = (k == lat);
            o = '0; o.stall = 1'b1; o.wr_en_dm = 1'b1; o.wb_sel = 1'b1;
            o.beat_idx = 2'(b); o.dirty_clr = i.done && (b == WPL - 1);
            add(i, o);
          end
      end
      for (int b = 0; b < WPL; b++)
        for (int k = 1; k <= lat; k++) begin
          i.done = (k == lat);
          o = '0; o.stall = 1'b1; o.rd_en_dm = 1'b1; o.beat_idx = 2'(b);
          o.m2c = i.done; o.valid_set = i.done && (b == WPL - 1);
          add(i, o);
        end
      i.hit = 1'b1; i.done = dn_ign;
      o = '0; o.rd_en_cm = !ew; o.wr_en_cm = ew; o.dirty_set = ew;
      add(i, o);
    end
    add('0, '0);
  endtask

  task automatic drive(input bit wb, input in_t i);
    if (wb) begin in_wb = i; in_wt = '0; end
    else    begin in_wt = i; in_wb = '0; end
  endtask

  // Apply the queued stream to one instance and compare every cycle
  task automatic run_q(input bit wb, input string name);
    out_t o;
    t_stall = 0; t_m2c = 0; t_vset = 0; t_wbsel = 0; t_dclr = 0;
    t_dset = 0; t_wrdm = 0; t_rdcm = 0; t_wrcm = 0;
    foreach (q[k]) begin
      @(posedge clk); #1;
      drive(wb, q[k].i);
      @(negedge clk);
      o = wb ? o_wb : o_wt;
      chk($sformatf("%s cyc%0d", name, k), 32'(o), 32'(q[k].o));
      t_stall += int'(o.stall);    t_m2c  += int'(o.m2c);      t_vset += int'(o.valid_set);
      t_wbsel += int'(o.wb_sel);   t_dclr += int'(o.dirty_clr); t_dset += int'(o.dirty_set);
      t_wrdm  += int'(o.wr_en_dm); t_rdcm += int'(o.rd_en_cm);  t_wrcm += int'(o.wr_en_cm);
    end
    q.delete();
  endtask

  initial begin
    in_t bi;
    for (int m = 0; m < 2; m++) begin nhit[m] = 0; nmiss[m] = 0; nwb[m] = 0; end

    // Reset with active requests: outputs must stay low
    in_wt = 5'b10001; in_wb = 5'b01011;
    #12;
    chk("reset outputs wt", 32'(o_wt), 32'd0);
    chk("reset outputs wb", 32'(o_wb), 32'd0);
    @(negedge clk);
    in_wt = '0; in_wb = '0;
    rst = 1'b1;

    gen_access(0, 1, 0, 1, 0, 1, 0);  run_q(0, "wt_rd_hit");
    chk("wt_rd_hit rd_en_cm count", t_rdcm, 1);
    chk("wt_rd_hit stall count", t_stall, 0);

    gen_access(0, 1, 0, 0, 1, 2, 1);  run_q(0, "wt_rd_miss");
    chk("wt_rd_miss stall cycles", t_stall, 9);
    chk("wt_rd_miss m2c pulses", t_m2c, 4);
    chk("wt_rd_miss valid_set", t_vset, 1);

    gen_access(1, 0, 1, 0, 1, 1, 0);  run_q(1, "wb_wr_miss_dirty");
    chk("wb_wr_miss wb_sel cycles", t_wbsel, 4);
    chk("wb_wr_miss dirty_clr", t_dclr, 1);
    chk("wb_wr_miss m2c pulses", t_m2c, 4);
    chk("wb_wr_miss stall cycles", t_stall, 9);
    chk("wb_wr_miss dirty_set", t_dset, 1);

    gen_access(0, 0, 1, 1, 0, 2, 0);  run_q(0, "wt_wr_hit");
    chk("wt_wr_hit wr_en_dm cycles", t_wrdm, 3);
    chk("wt_wr_hit stall cycles", t_stall, 2);
    chk("wt_wr_hit dirty_set", t_dset, 0);

    gen_access(0, 0, 1, 0, 1, 1, 1);  run_q(0, "wt_wr_miss");
    gen_access(1, 1, 0, 0, 0, 3, 1);  run_q(1, "wb_rd_miss_clean");
    gen_access(1, 0, 1, 1, 1, 1, 0);  run_q(1, "wb_wr_hit");
    gen_access(0, 1, 1, 1, 0, 1, 0);  run_q(0, "wt_rdwr_hit");
    chk("wt_rdwr_hit wr_en_cm", t_wrcm, 0);
    gen_access(1, 1, 1, 1, 0, 1, 0);  run_q(1, "wb_rdwr_hit");
    chk("wb_rdwr_hit wr_en_cm", t_wrcm, 0);
    gen_access(1, 1, 1, 0, 1, 2, 0);  run_q(1, "wb_rdwr_miss_dirty");
    chk("wb_rdwr_miss rd_en_cm", t_rdcm, 1);

    // Reset during refill beat 2 of a read miss
    gen_access(0, 1, 0, 0, 0, 1, 0);
    q = q[0:2];
    run_q(0, "pre_reset");
    @(posedge clk); #1;
    bi = '0; bi.rd = 1'b1; bi.done = 1'b1;
    drive(0, bi);
    #1;
    chk("refill beat2 m2c", 32'(o_wt.m2c), 32'd1);
    chk("refill beat2 beat_idx", 32'(o_wt.beat_idx), 32'd2);
    rst = 1'b0;
    #1;
    chk("mid-refill reset wt", 32'(o_wt), 32'd0);
    chk("mid-refill reset wb", 32'(o_wb), 32'd0);
    @(posedge clk); #1;
    chk("held reset wt", 32'(o_wt), 32'd0);
    for (int m = 0; m < 2; m++) begin nhit[m] = 0; nmiss[m] = 0; nwb[m] = 0; end
    rst = 1'b1;
    drive(0, '0);

    gen_access(0, 1, 0, 1, 0, 1, 0);  run_q(0, "post_reset_rd_hit");
    chk("post_reset valid_set", t_vset, 0);
    chk("post_reset rd_en_cm", t_rdcm, 1);
    gen_access(1, 1, 0, 1, 0, 1, 0);  run_q(1, "post_reset_wb_rd_hit");
    gen_access(1, 0, 1, 0, 1, 2, 0);  run_q(1, "post_reset_wb_wr_miss");

`ifdef CACHE_CTRL_PERF_EN
    chk("wt hit_cnt",  hc_wt, 32'(nhit[0]));
    chk("wt miss_cnt", mc_wt, 32'(nmiss[0]));
    chk("wt wb_cnt",   wc_wt, 32'(nwb[0]));
    chk("wb hit_cnt",  hc_wb, 32'(nhit[1]));
    chk("wb miss_cnt", mc_wb, 32'(nmiss[1]));
    chk("wb wb_cnt",   wc_wb, 32'(nwb[1]));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
